// File: rtl/mem_load_if.sv
// Handshake and data bundle between a load requester and mem_load_unit.
// The unit takes the slave view; the requester/memory side takes the master view.
interface mem_load_if;
  logic        start;
  logic [1:0]  load_type;
  logic [31:0] addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic [31:0] mdr_out;
  logic [7:0]  byte_out;

  modport slave (
    input  start, load_type, addr, mem_data_in,
    output mem_addr, mem_read, busy, done, misaligned, mdr_out, byte_out
  );

  modport master (
    output start, load_type, addr, mem_data_in,
    input  mem_addr, mem_read, busy, done, misaligned, mdr_out, byte_out
  );
endinterface

// File: rtl/mem_load_unit.sv
// Load unit: issues one aligned memory read, waits MEM_WAIT cycles, then
// extracts and zero-extends the addressed word/halfword/byte into the MDR.
module mem_load_unit #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_load_if.slave     bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [1:0] LT_WORD = 2'b00;
  localparam logic [1:0] LT_HALF = 2'b01;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

  logic [2:0]  state;
  logic [3:0]  wait_cnt;
  logic [31:0] addr_q;
  logic [1:0]  type_q;
  logic [31:0] mdr_q;

  logic        req_misaligned;
  logic [31:0] byte_shifted;
  logic [31:0] load_data;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    req_misaligned = 1'b0;
    case (bus.load_type)
      LT_WORD: req_misaligned = (bus.addr[1:0] != 2'b00);
      LT_HALF: req_misaligned = bus.addr[0];
      default: req_misaligned = 1'b0;
    endcase
  end

  assign byte_shifted = bus.mem_data_in >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = '0;
    case (type_q)
      LT_WORD: load_data = bus.mem_data_in;
      LT_HALF: load_data = {16'b0, addr_q[1] ? bus.mem_data_in[31:16] : bus.mem_data_in[15:0]};
      default: load_data = {24'b0, byte_shifted[7:0]};
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      type_q   <= '0;
      mdr_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            addr_q <= bus.addr;
            type_q <= bus.load_type;
            state  <= req_misaligned ? S_ERR : S_READ;
          end
        end
        S_READ: begin
          wait_cnt <= WAIT_INIT;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            mdr_q <= load_data;
            state <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state, so reset clears them with the FSM.
  assign bus.mem_read   = (state == S_READ);
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE) || (state == S_ERR);
  assign bus.misaligned = (state == S_ERR);
  assign bus.mem_addr   = {addr_q[31:2], 2'b00};
  assign bus.mdr_out    = mdr_q;
  assign bus.byte_out   = mdr_q[7:0];

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit: default MEM_WAIT=2 instance plus a
// MEM_WAIT=1 instance for the short-latency case.
module tb_mem_load_unit;

  localparam logic [31:0] JUNK = 32'hA5A5_A5A5;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_load_if bus ();
  mem_load_if bus1 ();

  mem_load_unit #(.MEM_WAIT(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  mem_load_unit #(.MEM_WAIT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request on bus; cycle 1 is the cycle after start is sampled.
  // Data is valid only in cycle 1+wait_n, junk otherwise.
  task automatic run_load(input logic [31:0] a, input logic [1:0] t, input logic [31:0] d,
                          input int wait_n, output int rd_cyc, output int rd_cnt,
                          output logic [31:0] rd_addr, output int done_cyc, output logic mis);
    @(negedge clk);
    bus.start = 1'b1; bus.addr = a; bus.load_type = t; bus.mem_data_in = JUNK;
    @(posedge clk); #1;
    bus.start = 1'b0;
    rd_cyc = -1; rd_cnt = 0; rd_addr = '0; done_cyc = -1; mis = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      bus.mem_data_in = (c == 1 + wait_n) ? d : JUNK;
      @(negedge clk);
      if (bus.mem_read) begin
        rd_cnt++;
        if (rd_cyc < 0) begin rd_cyc = c; rd_addr = bus.mem_addr; end
      end
      if (bus.done) begin done_cyc = c; mis = bus.misaligned; break; end
      @(posedge clk); #1;
    end
    bus.mem_data_in = JUNK;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [1:0]  t;
    logic [31:0] d;
    logic [31:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int rd_cyc, rd_cnt, done_cyc, seen;
    logic [31:0] rd_addr;
    logic mis;

    total = 0; bad = 0;
    bus.start = 1'b0; bus.addr = '0; bus.load_type = '0; bus.mem_data_in = JUNK;
    bus1.start = 1'b0; bus1.addr = '0; bus1.load_type = '0; bus1.mem_data_in = JUNK;

    // Reset with start held high: reset must win.
    reset = 1'b1;
    bus.start = 1'b1; bus.addr = 32'h10;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_mem_read", 32'(bus.mem_read), 0);
    check("rst_misaligned", 32'(bus.misaligned), 0);
    check("rst_mdr", bus.mdr_out, 0);
    check("rst_mem_addr", bus.mem_addr, 0);

    // Word load with full latency checks.
    run_load(32'h10, 2'b00, 32'hDEAD_BEEF, 2, rd_cyc, rd_cnt, rd_addr, done_cyc, mis);
    check("word_rd_cyc", 32'(rd_cyc), 1);
    check("word_rd_cnt", 32'(rd_cnt), 1);
    check("word_mem_addr", rd_addr, 32'h10);
    check("word_done_cyc", 32'(done_cyc), 4);
    check("word_mis", 32'(mis), 0);
    check("word_mdr", bus.mdr_out, 32'hDEAD_BEEF);

    vecs[0] = '{32'h13, 2'b10, 32'h80FF_7F01, 32'h80, "byte3"};
    vecs[1] = '{32'h10, 2'b10, 32'h80FF_7F01, 32'h01, "byte0"};
    vecs[2] = '{32'h11, 2'b10, 32'h80FF_7F01, 32'h7F, "byte1"};
    vecs[3] = '{32'h12, 2'b10, 32'h80FF_7F01, 32'hFF, "byte2"};
    vecs[4] = '{32'h23, 2'b11, 32'h5566_7788, 32'h55, "rsvd_byte3"};
    vecs[5] = '{32'h22, 2'b01, 32'hCAFE_1234, 32'hCAFE, "half_hi"};
    vecs[6] = '{32'h20, 2'b01, 32'hCAFE_1234, 32'h1234, "half_lo"};
    foreach (vecs[i]) begin
      run_load(vecs[i].a, vecs[i].t, vecs[i].d, 2, rd_cyc, rd_cnt, rd_addr, done_cyc, mis);
      check({vecs[i].tag, "_mem_addr"}, rd_addr, vecs[i].a & 32'hFFFF_FFFC);
      check({vecs[i].tag, "_done_cyc"}, 32'(done_cyc), 4);
      check({vecs[i].tag, "_mdr"}, bus.mdr_out, vecs[i].exp);
      check({vecs[i].tag, "_byte_out"}, 32'(bus.byte_out), vecs[i].exp & 32'hFF);
    end

    // Misaligned word and halfword: done+misaligned at cycle 1, no read, MDR kept.
    run_load(32'h06, 2'b00, 32'h1111_1111, 2, rd_cyc, rd_cnt, rd_addr, done_cyc, mis);
    check("misw_done_cyc", 32'(done_cyc), 1);
    check("misw_mis", 32'(mis), 1);
    check("misw_rd_cnt", 32'(rd_cnt), 0);
    check("misw_mdr", bus.mdr_out, 32'h1234);
    run_load(32'h21, 2'b01, 32'h2222_2222, 2, rd_cyc, rd_cnt, rd_addr, done_cyc, mis);
    check("mish_done_cyc", 32'(done_cyc), 1);
    check("mish_mis", 32'(mis), 1);
    check("mish_rd_cnt", 32'(rd_cnt), 0);
    check("mish_mdr", bus.mdr_out, 32'h1234);
    @(negedge clk);
    check("mis_after_idle", 32'(bus.busy), 0);

    // Reset while in WAIT; data on the old sample cycle must not land.
    @(negedge clk);
    bus.start = 1'b1; bus.addr = 32'h30; bus.load_type = 2'b00;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_pre_busy", 32'(bus.busy), 1);
    @(posedge clk); #1 reset = 1'b0; bus.mem_data_in = 32'h1234_5678;
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_mdr", bus.mdr_out, 0);
    check("midrst_mem_addr", bus.mem_addr, 0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1 bus.mem_data_in = JUNK;
      @(negedge clk);
      if (bus.done || bus.mem_read) seen++;
    end
    check("midrst_no_done", 32'(seen), 0);
    check("midrst_mdr_late", bus.mdr_out, 0);

    // Start during WAIT ignored; start the cycle after done accepted.
    @(negedge clk);
    bus.start = 1'b1; bus.addr = 32'h10; bus.load_type = 2'b00;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 bus.start = 1'b1; bus.addr = 32'h44;
    @(posedge clk); #1 bus.start = 1'b0; bus.mem_data_in = 32'h1111_2222;
    @(negedge clk);
    check("b2b_addr_held", bus.mem_addr, 32'h10);
    @(posedge clk); #1 bus.mem_data_in = JUNK;
    @(negedge clk);
    check("b2b_done", 32'(bus.done), 1);
    check("b2b_mdr", bus.mdr_out, 32'h1111_2222);
    @(posedge clk); #1 bus.start = 1'b1;
    @(negedge clk);
    check("b2b_idle_after_done", 32'(bus.busy), 0);
    check("b2b_addr_after_done", bus.mem_addr, 32'h10);
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    check("b2b_accepted_busy", 32'(bus.busy), 1);
    check("b2b_accepted_read", 32'(bus.mem_read), 1);
    check("b2b_accepted_addr", bus.mem_addr, 32'h44);
    seen = 0;
    for (int c = 0; c < 10 && !bus.done; c++) begin
      @(negedge clk);
      seen = bus.done ? 1 : seen;
    end
    check("b2b_second_done", 32'(seen), 1);

    // MEM_WAIT=1 instance: read at cycle 1, sample at 2, done at 3.
    @(negedge clk);
    bus1.start = 1'b1; bus1.addr = 32'h08; bus1.load_type = 2'b00;
    @(posedge clk); #1 bus1.start = 1'b0;
    done_cyc = -1; rd_cyc = -1;
    for (int c = 1; c <= 10; c++) begin
      bus1.mem_data_in = (c == 2) ? 32'h0BAD_F00D : JUNK;
      @(negedge clk);
      if (bus1.mem_read && rd_cyc < 0) rd_cyc = c;
      if (bus1.done) begin done_cyc = c; break; end
      @(posedge clk); #1;
    end
    check("w1_rd_cyc", 32'(rd_cyc), 1);
    check("w1_done_cyc", 32'(done_cyc), 3);
    check("w1_mdr", bus1.mdr_out, 32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
